// File: rtl/mover_2d_rd_fetch_pkg.sv
`default_nettype none
// ============================================================================
// mover_2d_rd_fetch_pkg
// Shared AXI encodings, fetch FSM states and the 4KB page constant.
// Revision: 1.0
// ============================================================================
package mover_2d_rd_fetch_pkg;

    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam int unsigned BOUNDARY_4KB    = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mover_2d_rd_fifo.sv
`default_nettype none
// ============================================================================
// mover_2d_rd_fifo
// Synchronous FIFO carrying a data word plus end-of-row tag, with free count.
// Revision: 1.0
// ============================================================================
module mover_2d_rd_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     push_eor_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        pop_data_o,
    output logic                     pop_eor_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   free_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    // A push at full is still taken when the same cycle pops a slot free.
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign free_o  = (AW+1)'(DEPTH) - count_q;
    assign {pop_eor_o, pop_data_o} = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= {push_eor_i, push_data_i};
    end

endmodule
`default_nettype wire

// File: rtl/mover_2d_rd_fetch.sv
`default_nettype none
// ============================================================================
// mover_2d_rd_fetch
// 2D strided AXI4 read fetcher feeding a credit-protected output FIFO.
// Optional macro MOVER_RD_4KB_SPLIT_EN splits bursts at 4KB page boundaries.
// Revision: 1.0
// ============================================================================
module mover_2d_rd_fetch #(
    parameter int AXI_WIDTH_ADDR = 32,
    parameter int AXI_WIDTH_DATA = 32,
    parameter int AXI_WIDTH_ID   = 4,
    parameter int MAX_BURST      = 16,
    parameter int FIFO_DEPTH     = 64
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      go,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic [AXI_WIDTH_ADDR-1:0] cfg_src_addr,
    input  logic [11:0]               cfg_width,
    input  logic [11:0]               cfg_height,
    input  logic [15:0]               cfg_stride,
    output logic [AXI_WIDTH_ID-1:0]   ARID,
    output logic [AXI_WIDTH_ADDR-1:0] ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [AXI_WIDTH_ID-1:0]   RID,
    input  logic [AXI_WIDTH_DATA-1:0] RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,
    output logic [AXI_WIDTH_DATA-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_eor
);
    import mover_2d_rd_fetch_pkg::*;

    localparam int         CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] C_SIZE      = 3'($clog2(AXI_WIDTH_DATA / 8));
    localparam logic [8:0] C_MAX_BURST = 9'(MAX_BURST);

    state_e                    state_q, state_d;
    logic [AXI_WIDTH_ADDR-1:0] row_addr_q, row_addr_d;
    logic [AXI_WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [11:0]               width_q, width_d;
    logic [11:0]               rows_q, rows_d;
    logic [11:0]               rem_q, rem_d;
    logic [11:0]               col_q, col_d;
    logic [15:0]               stride_q, stride_d;
    logic [8:0]                len_q, len_d;
    logic [CW-1:0]             outst_q, outst_d;
    logic                      error_q, error_d;

    logic [8:0]                w_len;
    logic [CW-1:0]             w_free;
    logic                      w_empty;
    logic                      w_fifo_full;
    logic                      w_credit_ok;
    logic                      w_rbeat;
    logic                      w_ar_hs;
    logic                      w_eor_in;
    logic                      w_unused;
`ifdef MOVER_RD_4KB_SPLIT_EN
    logic [12:0]               w_to_4k;
`endif

    always_comb begin
        w_len = (rem_q > 12'(C_MAX_BURST)) ? C_MAX_BURST : rem_q[8:0];
`ifdef MOVER_RD_4KB_SPLIT_EN
        w_to_4k = (13'(BOUNDARY_4KB) - {1'b0, addr_q[11:0]}) >> C_SIZE;
        if ({4'd0, w_len} > w_to_4k) w_len = w_to_4k[8:0];
`endif
    end

    // Reserve FIFO space for every beat in flight so R never needs backpressure.
    assign w_credit_ok = (16'(w_free) >= (16'(outst_q) + 16'(w_len)));
    assign w_rbeat     = RVALID && RREADY && (state_q != ST_IDLE);
    assign w_ar_hs     = (state_q == ST_ADDR) && ARREADY;
    assign w_eor_in    = (col_q == (width_q - 12'd1));

    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        addr_d     = addr_q;
        width_d    = width_q;
        rows_d     = rows_q;
        rem_d      = rem_q;
        col_d      = col_q;
        stride_d   = stride_q;
        len_d      = len_q;
        error_d    = error_q;
        outst_d    = outst_q + (w_ar_hs ? CW'(len_q) : CW'(0)) - (w_rbeat ? CW'(1) : CW'(0));

        if (w_rbeat) begin
            col_d = w_eor_in ? 12'd0 : col_q + 12'd1;
            if (RRESP != AXI_RESP_OKAY) error_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    width_d    = cfg_width;
                    rows_d     = cfg_height;
                    stride_d   = cfg_stride;
                    row_addr_d = cfg_src_addr;
                    addr_d     = cfg_src_addr;
                    rem_d      = cfg_width;
                    col_d      = 12'd0;
                    error_d    = 1'b0;
                    state_d    = (cfg_width == 12'd0 || cfg_height == 12'd0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_credit_ok) begin
                    len_d   = w_len;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ARREADY) begin
                    if (rem_q == 12'(len_q)) begin
                        if (rows_q == 12'd1) begin
                            state_d = ST_DRAIN;
                        end else begin
                            rows_d     = rows_q - 12'd1;
                            row_addr_d = row_addr_q + AXI_WIDTH_ADDR'(stride_q);
                            addr_d     = row_addr_q + AXI_WIDTH_ADDR'(stride_q);
                            rem_d      = width_q;
                            state_d    = ST_CALC;
                        end
                    end else begin
                        rem_d   = rem_q - 12'(len_q);
                        addr_d  = addr_q + (AXI_WIDTH_ADDR'(len_q) << C_SIZE);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0 && w_empty) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            row_addr_q <= '0;
            addr_q     <= '0;
            width_q    <= '0;
            rows_q     <= '0;
            rem_q      <= '0;
            col_q      <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            outst_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_addr_q <= row_addr_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            rows_q     <= rows_d;
            rem_q      <= rem_d;
            col_q      <= col_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            outst_q    <= outst_d;
            error_q    <= error_d;
        end
    end

    mover_2d_rd_fifo #(
        .DATA_W (AXI_WIDTH_DATA),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .push_i      (w_rbeat),
        .push_data_i (RDATA),
        .push_eor_i  (w_eor_in),
        .pop_i       (out_ready),
        .pop_data_o  (out_data),
        .pop_eor_o   (out_eor),
        .full_o      (w_fifo_full),
        .empty_o     (w_empty),
        .free_o      (w_free)
    );

    assign ARVALID   = (state_q == ST_ADDR);
    assign ARADDR    = addr_q;
    assign ARLEN     = 8'(len_q - 9'd1);
    assign ARSIZE    = C_SIZE;
    assign ARBURST   = AXI_BURST_INCR;
    assign ARID      = '0;
    assign RREADY    = !ARESET;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign error     = error_q;
    assign out_valid = !w_empty;
    assign w_unused  = ^{RID, RLAST, w_fifo_full};

endmodule
`default_nettype wire

// File: tb/tb_mover_2d_rd_fetch.sv
`default_nettype none
// ============================================================================
// tb_mover_2d_rd_fetch
// Randomized AXI slave and output sink checked against a transfer-level model.
// ============================================================================
module tb_mover_2d_rd_fetch;
    localparam int MB = 16;
    localparam int FD = 64;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        go = 1'b0;
    logic        busy, done, error;
    logic [31:0] cfg_src_addr = '0;
    logic [11:0] cfg_width = '0, cfg_height = '0;
    logic [15:0] cfg_stride = '0;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_eor;

    mover_2d_rd_fetch #(
        .AXI_WIDTH_ADDR(32), .AXI_WIDTH_DATA(32), .AXI_WIDTH_ID(4),
        .MAX_BURST(MB), .FIFO_DEPTH(FD)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .go(go), .busy(busy), .done(done), .error(error),
        .cfg_src_addr(cfg_src_addr), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_stride(cfg_stride), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_eor(out_eor)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
    } ar_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    ar_t         obs_ar[$];
    logic [32:0] obs_beat[$];
    logic [31:0] pend_addr[$];
    logic        pend_last[$];
    logic [31:0] exp_ar_addr[$];
    int          exp_ar_len[$];
    logic [32:0] exp_beat[$];
    int          inflight = 0, peak = 0, done_cnt = 0;
    logic        err_at_done = 1'b0;
    int          rdy_mode = 2;
    logic        bad_en = 1'b0;
    logic [31:0] bad_addr = '0;
    logic [31:0] salt = 32'h1234_5678;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Reference: rows walk by stride, each row cut into bursts by size and page limits.
    function automatic void build_model(input logic [31:0] base, input int w, input int h, input int s);
        logic [31:0] rs, a;
        int          left, l, room;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_beat.delete();
        for (int r = 0; r < h; r++) begin
            rs = base + 32'(r * s);
            for (int c = 0; c < w; c++) exp_beat.push_back({(c == w - 1), dfun(rs + 32'(4 * c))});
            a = rs;
            left = w;
            while (left > 0) begin
                l = (left < MB) ? left : MB;
`ifdef MOVER_RD_4KB_SPLIT_EN
                room = (4096 - int'(a[11:0])) / 4;
                if (room < l) l = room;
`else
                room = 0;
`endif
                exp_ar_addr.push_back(a);
                exp_ar_len.push_back(l);
                a = a + 32'(4 * l);
                left = left - l;
            end
        end
    endfunction

    // AXI slave + stream sink: observe at negedge, drive just after posedge.
    initial begin
        logic rcons;
        ARREADY = 0; RVALID = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; out_ready = 0;
        forever begin
            @(negedge ACLK);
            rcons = RVALID && RREADY;
            if (ARVALID && ARREADY) begin
                obs_ar.push_back('{ARADDR, ARLEN, ARSIZE, ARBURST, ARID});
                for (int i = 0; i <= int'(ARLEN); i++) begin
                    pend_addr.push_back(ARADDR + 32'(4 * i));
                    pend_last.push_back(i == int'(ARLEN));
                end
                inflight += int'(ARLEN) + 1;
            end
            if (rcons) begin
                void'(pend_addr.pop_front());
                void'(pend_last.pop_front());
            end
            if (out_valid && out_ready) begin
                obs_beat.push_back({out_eor, out_data});
                inflight--;
            end
            if (inflight > peak) peak = inflight;
            if (done) begin
                done_cnt++;
                err_at_done = error;
            end
            @(posedge ACLK); #1;
            ARREADY = ($urandom_range(0, 3) != 0);
            if (!(RVALID && !rcons)) begin
                if (pend_addr.size() > 0 && $urandom_range(0, 3) != 0) begin
                    RVALID = 1;
                    RDATA  = dfun(pend_addr[0]);
                    RLAST  = pend_last[0];
                    RRESP  = (bad_en && pend_addr[0] == bad_addr) ? 2'b10 : 2'b00;
                end else begin
                    RVALID = 0; RLAST = 0; RRESP = 0;
                end
            end
            out_ready = (rdy_mode == 2) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic start_xfer(input logic [31:0] a, input int w, input int h, input int s);
        @(posedge ACLK); #1;
        obs_ar.delete(); obs_beat.delete();
        inflight = 0; peak = 0; done_cnt = 0; err_at_done = 0;
        build_model(a, w, h, s);
        cfg_src_addr = a; cfg_width = 12'(w); cfg_height = 12'(h); cfg_stride = 16'(s);
        go = 1;
        @(posedge ACLK); #1;
        go = 0;
    endtask

    task automatic wait_done(input int lim, output logic to);
        int c;
        c = 0;
        while (done_cnt == 0 && c < lim) begin
            @(posedge ACLK);
            c++;
        end
        to = (done_cnt == 0);
        repeat (4) @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset;
        ARESET = 1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        n_cmp++;
        if ({ARVALID, RREADY, out_valid, busy, done, error} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b exp 000000", {ARVALID, RREADY, out_valid, busy, done, error});
        end
        @(posedge ACLK); #1;
        ARESET = 0;
        @(negedge ACLK);
        n_cmp++;
        if ({RREADY, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL post_reset_rready_busy got %b exp 10", {RREADY, busy});
        end
    endtask

    task automatic test_basic;
        logic to;
        int   eor_cnt;
        rdy_mode = 2;
        start_xfer(32'h1000, 8, 2, 64);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b exp 1", busy); end
        wait_done(2000, to);
        n_cmp++;
        if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got %b exp 0", to); end
        n_cmp++;
        if (obs_ar.size() != 2) begin n_bad++; $display("FAIL basic_ar_count got %0d exp 2", obs_ar.size()); end
        else begin
            n_cmp++;
            if (obs_ar[0] !== '{32'h1000, 8'd7, 3'd2, 2'b01, 4'd0}) begin
                n_bad++; $display("FAIL basic_ar0 got %h/%0d exp 1000/7", obs_ar[0].addr, obs_ar[0].len);
            end
            n_cmp++;
            if (obs_ar[1] !== '{32'h1040, 8'd7, 3'd2, 2'b01, 4'd0}) begin
                n_bad++; $display("FAIL basic_ar1 got %h/%0d exp 1040/7", obs_ar[1].addr, obs_ar[1].len);
            end
        end
        eor_cnt = 0;
        for (int i = 0; i < obs_beat.size(); i++) if (obs_beat[i][32]) eor_cnt++;
        n_cmp++;
        if (obs_beat.size() != 16 || obs_beat[7][32] !== 1'b1 || obs_beat[15][32] !== 1'b1 || eor_cnt != 2) begin
            n_bad++; $display("FAIL basic_beats_eor got n=%0d eor=%0d exp n=16 eor=2", obs_beat.size(), eor_cnt);
        end
        for (int i = 0; i < exp_beat.size() && i < obs_beat.size(); i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_bad++; $display("FAIL basic_beat[%0d] got %h exp %h", i, obs_beat[i], exp_beat[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_done got pulses=%0d busy=%b exp 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_transfers;
        logic [31:0] ca[4] = '{32'h2000, 32'h0FF8, 32'h5000, 32'h5000};
        int          cw[4] = '{40, 8, 0, 5};
        int          ch[4] = '{1, 1, 3, 0};
        logic [31:0] a;
        int          w, h, s;
        logic        to;
        for (int t = 0; t < 12; t++) begin
            if (t < 4) begin
                a = ca[t]; w = cw[t]; h = ch[t]; s = 256; rdy_mode = 2;
            end else begin
                a = 32'($urandom_range(0, 32'h3FFF)) << 2;
                w = $urandom_range(1, 40); h = $urandom_range(1, 4);
                s = 4 * w + 4 * $urandom_range(0, 8); rdy_mode = 1;
            end
            start_xfer(a, w, h, s);
            wait_done(20000, to);
            n_cmp++;
            if (to !== 1'b0 || done_cnt != 1) begin
                n_bad++; $display("FAIL xfer%0d_done got timeout=%b pulses=%0d exp 0/1", t, to, done_cnt);
            end
            n_cmp++;
            if (obs_ar.size() != exp_ar_addr.size()) begin
                n_bad++; $display("FAIL xfer%0d_ar_count got %0d exp %0d", t, obs_ar.size(), exp_ar_addr.size());
            end
            for (int i = 0; i < obs_ar.size() && i < exp_ar_addr.size(); i++) begin
                n_cmp++;
                if (obs_ar[i] !== '{exp_ar_addr[i], 8'(exp_ar_len[i] - 1), 3'd2, 2'b01, 4'd0}) begin
                    n_bad++; $display("FAIL xfer%0d_ar[%0d] got %h/%0d exp %h/%0d", t, i,
                        obs_ar[i].addr, obs_ar[i].len, exp_ar_addr[i], exp_ar_len[i] - 1);
                end
            end
            n_cmp++;
            if (obs_beat.size() != exp_beat.size()) begin
                n_bad++; $display("FAIL xfer%0d_beat_count got %0d exp %0d", t, obs_beat.size(), exp_beat.size());
            end
            for (int i = 0; i < obs_beat.size() && i < exp_beat.size(); i++) begin
                n_cmp++;
                if (obs_beat[i] !== exp_beat[i]) begin
                    n_bad++; $display("FAIL xfer%0d_beat[%0d] got %h exp %h", t, i, obs_beat[i], exp_beat[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic to;
        rdy_mode = 0;
        start_xfer(32'h3000, 100, 1, 400);
        repeat (50) @(posedge ACLK);
        #1;
        cfg_src_addr = 32'h9000; cfg_width = 12'd3; cfg_height = 12'd1;
        go = 1;
        @(posedge ACLK); #1;
        go = 0;
        repeat (250) @(posedge ACLK);
        @(negedge ACLK);
        n_cmp++;
        if (peak != FD || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL bp_stall got reserved=%0d valid=%b busy=%b exp %0d/1/1", peak, out_valid, busy, FD);
        end
        rdy_mode = 1;
        wait_done(20000, to);
        n_cmp++;
        if (to !== 1'b0 || peak > FD) begin
            n_bad++; $display("FAIL bp_done got timeout=%b peak=%0d exp 0/<=%0d", to, peak, FD);
        end
        n_cmp++;
        if (obs_ar.size() != exp_ar_addr.size() || obs_beat.size() != exp_beat.size()) begin
            n_bad++; $display("FAIL bp_counts got ar=%0d beats=%0d exp %0d/%0d", obs_ar.size(), obs_beat.size(),
                exp_ar_addr.size(), exp_beat.size());
        end
        for (int i = 0; i < obs_beat.size() && i < exp_beat.size(); i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_bad++; $display("FAIL bp_beat[%0d] got %h exp %h", i, obs_beat[i], exp_beat[i]);
            end
        end
    endtask

    task automatic test_slverr;
        logic to;
        rdy_mode = 1;
        bad_en = 1; bad_addr = 32'h6000 + 32'd20;
        start_xfer(32'h6000, 12, 2, 64);
        wait_done(20000, to);
        bad_en = 0;
        n_cmp++;
        if (to !== 1'b0 || err_at_done !== 1'b1 || error !== 1'b1) begin
            n_bad++; $display("FAIL slverr_flag got timeout=%b err_at_done=%b err=%b exp 0/1/1", to, err_at_done, error);
        end
        n_cmp++;
        if (obs_beat.size() != exp_beat.size()) begin
            n_bad++; $display("FAIL slverr_beat_count got %0d exp %0d", obs_beat.size(), exp_beat.size());
        end
        for (int i = 0; i < obs_beat.size() && i < exp_beat.size(); i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_bad++; $display("FAIL slverr_beat[%0d] got %h exp %h", i, obs_beat[i], exp_beat[i]);
            end
        end
        start_xfer(32'h6100, 4, 4, 16);
        n_cmp++;
        if (error !== 1'b0) begin n_bad++; $display("FAIL slverr_clear got %b exp 0", error); end
        wait_done(20000, to);
        n_cmp++;
        if (to !== 1'b0 || err_at_done !== 1'b0) begin
            n_bad++; $display("FAIL slverr_next got timeout=%b err=%b exp 0/0", to, err_at_done);
        end
    endtask

    task automatic test_reset_mid;
        logic to;
        int   c;
        rdy_mode = 1;
        start_xfer(32'h7000, 64, 4, 256);
        repeat (30) @(posedge ACLK);
        #1;
        ARESET = 1;
        @(negedge ACLK);
        n_cmp++;
        if (RREADY !== 1'b0) begin n_bad++; $display("FAIL rstmid_rready got %b exp 0", RREADY); end
        @(negedge ACLK);
        n_cmp++;
        if ({ARVALID, out_valid, busy, done, error} !== 5'b0) begin
            n_bad++; $display("FAIL rstmid_outputs got %b exp 00000", {ARVALID, out_valid, busy, done, error});
        end
        @(posedge ACLK); #1;
        ARESET = 0;
        c = 0;
        while (pend_addr.size() > 0 && c < 2000) begin
            @(posedge ACLK);
            c++;
        end
        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        n_cmp++;
        if (pend_addr.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_discard got pend=%0d valid=%b busy=%b exp 0/0/0", pend_addr.size(), out_valid, busy);
        end
        start_xfer(32'h7800, 4, 4, 32);
        wait_done(20000, to);
        n_cmp++;
        if (to !== 1'b0 || obs_ar.size() != exp_ar_addr.size() || obs_beat.size() != exp_beat.size()) begin
            n_bad++; $display("FAIL rstmid_after got timeout=%b ar=%0d beats=%0d exp 0/%0d/%0d", to,
                obs_ar.size(), obs_beat.size(), exp_ar_addr.size(), exp_beat.size());
        end
        for (int i = 0; i < obs_beat.size() && i < exp_beat.size(); i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_bad++; $display("FAIL rstmid_beat[%0d] got %h exp %h", i, obs_beat[i], exp_beat[i]);
            end
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset;
        test_basic;
        test_transfers;
        test_backpressure;
        test_slverr;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
